zp_serial_tx: RTL and testbench

- Bit-serial frame transmitter for the zero/parity flag path.
- Accepts a WIDTH-bit word plus a mode bit over a valid/ready handshake.
- Shifts the word out LSB-first, framed by a start bit, a trailer bit and a stop bit.
- The trailer is computed exactly as zeroparity does: XOR of all data bits when mode=1, (data != 0) when mode=0. A receiver built on zeroparity can therefore check each frame.

---
 rtl/zp_serial_tx.sv | 172 +++++++++++++++++
 tb/tb_zp_serial_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/zp_serial_tx.sv
// Bit-serial frame transmitter: start bit, WIDTH data bits LSB-first, trailer, stop bit.
// The trailer is the parity or nonzero flag of the data, matching the zeroparity checker.
module zp_serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_TRAIL = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Trailer: parity of the word when mode=1, nonzero flag when mode=0.
  function automatic logic trailer_of(input logic [WIDTH-1:0] d, input logic m);
    logic t;
    if (m) begin
      t = ^d;
    end else begin
      t = |d;
    end
    return t;
  endfunction

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [IW-1:0]    idx_r, idx_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic             trail_r, trail_s;
  logic             tx_r, tx_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             ready_r, ready_s;
  logic             accept_s;
  logic             last_s;

  // Ready is held low for as long as reset is asserted.
  assign in_ready = rst_n & ready_r;
  assign accept_s = in_valid & in_ready;
  assign tx       = tx_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Next-state and next-output computation.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    trail_s = trail_r;
    tx_s    = 1'b1;
    last_s  = (cnt_r == CNT_LAST);

    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = S_START;
          cnt_s   = '0;
          shift_s = in_data;
          trail_s = trailer_of(in_data, in_mode);
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (last_s) begin
          state_s = S_DATA;
          cnt_s   = '0;
          idx_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_DATA: begin
        if (last_s) begin
          cnt_s   = '0;
          shift_s = shift_r >> 1;
          if (idx_r == IDX_LAST) begin
            state_s = S_TRAIL;
          end else begin
            idx_s = idx_r + IW'(1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_TRAIL: begin
        if (last_s) begin
          state_s = S_STOP;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_STOP: begin
        if (last_s) begin
          cnt_s = '0;
          // A word accepted on the last stop cycle starts with no idle gap.
          if (accept_s) begin
            state_s = S_START;
            shift_s = in_data;
            trail_s = trailer_of(in_data, in_mode);
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
      end
    endcase

    case (state_s)
      S_IDLE:  tx_s = 1'b1;
      S_START: tx_s = 1'b0;
      S_DATA:  tx_s = shift_s[0];
      S_TRAIL: tx_s = trail_s;
      S_STOP:  tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase

    busy_s  = (state_s != S_IDLE);
    done_s  = (state_s == S_STOP) && (cnt_s == CNT_LAST);
    ready_s = (state_s == S_IDLE) || done_s;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      shift_r <= '0;
      trail_r <= 1'b0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      trail_r <= trail_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      ready_r <= ready_s;
    end
  end

endmodule

// File: tb/tb_zp_serial_tx.sv
// Bench for zp_serial_tx: two builds (CLKS_PER_BIT=4 and 1) checked cycle by cycle
// against an expected-waveform queue built from the frame format.
module tb_zp_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       va, ra, ma, txa, busya, donea;
  logic [7:0] da;
  logic       vb, rb, mb, txb, busyb, doneb;
  logic [7:0] db;

  zp_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ra), .in_data(da),
    .in_mode(ma), .tx(txa), .busy(busya), .done(donea));

  zp_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rb), .in_data(db),
    .in_mode(mb), .tx(txb), .busy(busyb), .done(doneb));

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_tx[$];
  logic exp_busy[$];
  logic exp_done[$];

  // Expected line waveform for one frame: each bit repeated cpb cycles.
  function automatic void add_frame(input logic [7:0] d, input logic m, input int cpb);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    bits.push_back(m ? (^d) : (d != 8'h00));
    bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int r = 0; r < cpb; r++) begin
        exp_tx.push_back(bits[b]);
        exp_busy.push_back(1'b1);
        exp_done.push_back((b == bits.size() - 1) && (r == cpb - 1));
      end
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input bit sel);
    logic et, eb, ed;
    et = exp_tx.pop_front();
    eb = exp_busy.pop_front();
    ed = exp_done.pop_front();
    if (sel) begin
      chk("b_tx", txb, et); chk("b_busy", busyb, eb);
      chk("b_done", doneb, ed); chk("b_ready", rb, ed);
    end else begin
      chk("a_tx", txa, et); chk("a_busy", busya, eb);
      chk("a_done", donea, ed); chk("a_ready", ra, ed);
    end
  endtask

  task automatic check_idle(input bit sel, input logic exp_ready);
    if (sel) begin
      chk("b_idle_tx", txb, 1'b1); chk("b_idle_busy", busyb, 1'b0);
      chk("b_idle_done", doneb, 1'b0); chk("b_idle_ready", rb, exp_ready);
    end else begin
      chk("a_idle_tx", txa, 1'b1); chk("a_idle_busy", busya, 1'b0);
      chk("a_idle_done", donea, 1'b0); chk("a_idle_ready", ra, exp_ready);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic m);
    va = 1'b1; da = d; ma = m;
    add_frame(d, m, 4);
    @(negedge clk);
    va = 1'b0; da = 8'($urandom); ma = 1'($urandom);
    repeat (44) begin check_cycle(1'b0); @(negedge clk); end
    check_idle(1'b0, 1'b1);
  endtask

  task automatic send_b(input logic [7:0] d, input logic m);
    vb = 1'b1; db = d; mb = m;
    add_frame(d, m, 1);
    @(negedge clk);
    vb = 1'b0; db = 8'($urandom); mb = 1'($urandom);
    repeat (11) begin check_cycle(1'b1); @(negedge clk); end
    check_idle(1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    va = 1'b0; da = 8'h00; ma = 1'b0;
    vb = 1'b0; db = 8'h00; mb = 1'b0;
    repeat (2) @(negedge clk);
    check_idle(1'b0, 1'b0);
    check_idle(1'b1, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("a_ready_after_reset", ra, 1'b1);
    chk("b_ready_after_reset", rb, 1'b1);
    @(negedge clk);

    // Directed frames: parity and nonzero-flag trailers.
    send_a(8'hA5, 1'b1);
    send_a(8'h00, 1'b0);
    send_a(8'h80, 1'b0);
    send_a(8'h80, 1'b1);
    send_a(8'h03, 1'b1);

    // Back-to-back: second word accepted on the first frame's done cycle.
    va = 1'b1; da = 8'h3C; ma = 1'b1;
    add_frame(8'h3C, 1'b1, 4);
    add_frame(8'hFF, 1'b1, 4);
    @(negedge clk);
    da = 8'hFF;
    repeat (44) begin check_cycle(1'b0); @(negedge clk); end
    va = 1'b0;
    repeat (44) begin check_cycle(1'b0); @(negedge clk); end
    check_idle(1'b0, 1'b1);

    // Valid offered mid-frame while not ready must be ignored.
    va = 1'b1; da = 8'hC3; ma = 1'b0;
    add_frame(8'hC3, 1'b0, 4);
    @(negedge clk);
    va = 1'b0; da = 8'h00;
    for (int k = 1; k <= 44; k++) begin
      if (k == 10) begin va = 1'b1; da = 8'h12; ma = 1'b1; end
      if (k == 20) begin va = 1'b0; da = 8'h7E; end
      check_cycle(1'b0);
      @(negedge clk);
    end
    check_idle(1'b0, 1'b1);

    // Reset during data bit 3, then a clean frame.
    va = 1'b1; da = 8'h96; ma = 1'b1;
    add_frame(8'h96, 1'b1, 4);
    @(negedge clk);
    va = 1'b0;
    repeat (17) begin check_cycle(1'b0); @(negedge clk); end
    rst_n = 1'b0;
    @(negedge clk);
    check_idle(1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("a_ready_after_midreset", ra, 1'b1);
    exp_tx.delete(); exp_busy.delete(); exp_done.delete();
    @(negedge clk);
    check_idle(1'b0, 1'b1);
    send_a(8'h5A, 1'b0);

    // Randomised frames.
    repeat (6) send_a(8'($urandom), 1'($urandom));

    // Single-cycle-per-bit build.
    send_b(8'h01, 1'b1);
    repeat (5) send_b(8'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
